eth_frame_tx: RTL and testbench

Ethernet MAC transmit framer that sits directly upstream of the byte-wide receive/parse stage. It accepts a frame header and a payload byte stream and drives `out_txen`/`out_txd` with the complete on-wire octet sequence: preamble, SFD, destination MAC, source MAC, EtherType, payload, zero padding, FCS (CRC-32), then the inter-packet gap. It implements the transmitter side of the same 8-bit GMII-style byte bus that the receiver consumes.

---
 rtl/eth_frame_tx.sv | 208 ++++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// Ethernet MAC transmit framer: preamble/SFD, header, payload with zero padding,
// CRC-32 FCS and inter-packet gap on a registered byte-wide GMII-style bus.
module eth_frame_tx #(
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0] SFD_BYTE      = 8'hD5,
  parameter int         IPG_BYTES     = 12
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_start,
  input  logic [47:0] in_dest_mac,
  input  logic [47:0] in_src_mac,
  input  logic [15:0] in_ether_type,
  input  logic        in_data_valid,
  input  logic [7:0]  in_data,
  input  logic        in_data_last,
  output logic        out_data_ready,
  output logic        out_txen,
  output logic [7:0]  out_txd,
  output logic        out_busy,
  output logic        out_underrun,
  output logic        out_oversize
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DEST, S_SRC, S_TYPE, S_PAY, S_PAD, S_FCS, S_IPG
  } state_t;

  localparam logic [11:0] LAST_IPG  = 12'(IPG_BYTES - 1);
  localparam logic [11:0] MAX_PAY_M1 = 12'd1499;
  localparam logic [11:0] MIN_DATA  = 12'd46;

  // State and counter describe the octet currently on out_txd.
  state_t        r_state;
  logic [11:0]   r_cnt;
  logic [111:0]  r_hdr;
  logic [31:0]   r_crc;
  logic          r_pay_end;
  logic          r_txen;
  logic [7:0]    r_txd;
  logic          r_busy;
  logic          r_underrun;
  logic          r_oversize;

  logic          w_ready;
  logic          w_pay_max;
  logic [7:0]    w_hdr_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Ready looks only at where the frame is, never at in_data_valid.
  assign w_ready    = ((r_state == S_TYPE) && (r_cnt == 12'd1)) ||
                      ((r_state == S_PAY) && !r_pay_end);
  assign w_pay_max  = (r_state == S_PAY) && (r_cnt == MAX_PAY_M1);
  assign w_hdr_byte = r_hdr[111:104];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 12'd0;
      r_hdr      <= 112'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_pay_end  <= 1'b0;
      r_txen     <= 1'b0;
      r_txd      <= 8'h00;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_oversize <= 1'b0;
    end else if (w_ready) begin
      if (in_data_valid) begin
        r_state   <= S_PAY;
        r_cnt     <= (r_state == S_PAY) ? r_cnt + 12'd1 : 12'd1;
        r_txd     <= in_data;
        r_crc     <= crc_byte(r_crc, in_data);
        r_pay_end <= in_data_last | w_pay_max;
        if (w_pay_max && !in_data_last) begin
          r_oversize <= 1'b1;
        end
      end else begin
        r_state    <= S_IPG;
        r_cnt      <= 12'd0;
        r_txen     <= 1'b0;
        r_txd      <= 8'h00;
        r_underrun <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_state    <= S_PRE;
            r_cnt      <= 12'd0;
            r_hdr      <= {in_dest_mac, in_src_mac, in_ether_type};
            r_crc      <= 32'hFFFFFFFF;
            r_pay_end  <= 1'b0;
            r_txen     <= 1'b1;
            r_txd      <= PREAMBLE_BYTE;
            r_busy     <= 1'b1;
            r_underrun <= 1'b0;
            r_oversize <= 1'b0;
          end
        end
        S_PRE: begin
          if (r_cnt == 12'd6) begin
            r_state <= S_SFD;
            r_cnt   <= 12'd0;
            r_txd   <= SFD_BYTE;
          end else begin
            r_cnt <= r_cnt + 12'd1;
            r_txd <= PREAMBLE_BYTE;
          end
        end
        // Header octets shift out of r_hdr MSB first; S_TYPE only sees count 0 here.
        S_SFD, S_DEST, S_SRC, S_TYPE: begin
          r_txd <= w_hdr_byte;
          r_hdr <= r_hdr << 8;
          r_crc <= crc_byte(r_crc, w_hdr_byte);
          r_cnt <= r_cnt + 12'd1;
          case (r_state)
            S_SFD: begin
              r_state <= S_DEST;
              r_cnt   <= 12'd0;
            end
            S_DEST: begin
              if (r_cnt == 12'd5) begin
                r_state <= S_SRC;
                r_cnt   <= 12'd0;
              end
            end
            S_SRC: begin
              if (r_cnt == 12'd5) begin
                r_state <= S_TYPE;
                r_cnt   <= 12'd0;
              end
            end
            default: ;
          endcase
        end
        S_PAY: begin
          if (r_cnt < MIN_DATA) begin
            r_state <= S_PAD;
            r_cnt   <= r_cnt + 12'd1;
            r_txd   <= 8'h00;
            r_crc   <= crc_byte(r_crc, 8'h00);
          end else begin
            r_state <= S_FCS;
            r_cnt   <= 12'd0;
            r_txd   <= ~r_crc[7:0];
            r_crc   <= r_crc >> 8;
          end
        end
        // In PAD the counter holds the total data octets sent, including padding.
        S_PAD: begin
          if (r_cnt == MIN_DATA) begin
            r_state <= S_FCS;
            r_cnt   <= 12'd0;
            r_txd   <= ~r_crc[7:0];
            r_crc   <= r_crc >> 8;
          end else begin
            r_cnt <= r_cnt + 12'd1;
            r_txd <= 8'h00;
            r_crc <= crc_byte(r_crc, 8'h00);
          end
        end
        S_FCS: begin
          if (r_cnt == 12'd3) begin
            r_state <= S_IPG;
            r_cnt   <= 12'd0;
            r_txen  <= 1'b0;
            r_txd   <= 8'h00;
          end else begin
            r_cnt <= r_cnt + 12'd1;
            r_txd <= ~r_crc[7:0];
            r_crc <= r_crc >> 8;
          end
        end
        S_IPG: begin
          if (r_cnt == LAST_IPG) begin
            r_state <= S_IDLE;
            r_cnt   <= 12'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txen  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data_ready = w_ready;
  assign out_txen       = r_txen;
  assign out_txd        = r_txd;
  assign out_busy       = r_busy;
  assign out_underrun   = r_underrun;
  assign out_oversize   = r_oversize;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: random headers/payloads compared against a frame model
// built from the on-wire octet rules, plus underrun, oversize, back-to-back and reset cases.
module tb_eth_frame_tx;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [47:0] in_dest_mac = 48'd0;
  logic [47:0] in_src_mac = 48'd0;
  logic [15:0] in_ether_type = 16'd0;
  logic        in_data_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_data_last = 1'b0;
  logic        out_data_ready;
  logic        out_txen;
  logic [7:0]  out_txd;
  logic        out_busy;
  logic        out_underrun;
  logic        out_oversize;

  eth_frame_tx dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_start      (in_start),
    .in_dest_mac   (in_dest_mac),
    .in_src_mac    (in_src_mac),
    .in_ether_type (in_ether_type),
    .in_data_valid (in_data_valid),
    .in_data       (in_data),
    .in_data_last  (in_data_last),
    .out_data_ready(out_data_ready),
    .out_txen      (out_txen),
    .out_txd       (out_txd),
    .out_busy      (out_busy),
    .out_underrun  (out_underrun),
    .out_oversize  (out_oversize)
  );

  always #5 in_clk = ~in_clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  logic [7:0] body[$];
  logic [7:0] pay[$];
  int   low_run = 0;
  int   gap_at_rise = -1;
  logic prev_txen = 1'b0;

  // Collects every octet sent with txen high and the length of the last txen-low gap.
  always @(negedge in_clk) begin
    if (out_txen) begin
      cap.push_back(out_txd);
      if (!prev_txen) gap_at_rise = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_txen = out_txen;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reflected CRC-32 evaluated bit by bit, each octet LSB first.
  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[k][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic build_expected(input logic [47:0] d, input logic [47:0] s,
                                input logic [15:0] t, input int sent, input bit full);
    logic [31:0] c;
    logic [7:0]  tmp;
    exp_q.delete();
    body.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
    body.push_back(t[15:8]);
    body.push_back(t[7:0]);
    for (int i = 0; i < sent; i++) body.push_back(pay[i]);
    if (full) for (int i = sent; i < 46; i++) body.push_back(8'h00);
    foreach (body[i]) exp_q.push_back(body[i]);
    if (full) begin
      c = crc_of(body);
      for (int i = 0; i < 4; i++) begin
        tmp = c[8*i +: 8];
        exp_q.push_back(~tmp);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/rst_txen"},     32'(out_txen),       32'd0);
    check({name, "/rst_txd"},      32'(out_txd),        32'd0);
    check({name, "/rst_ready"},    32'(out_data_ready), 32'd0);
    check({name, "/rst_busy"},     32'(out_busy),       32'd0);
    check({name, "/rst_underrun"}, 32'(out_underrun),   32'd0);
    check({name, "/rst_oversize"}, 32'(out_oversize),   32'd0);
  endtask

  // Sends one frame. drop_at >= 0 withholds valid at that payload index; over
  // means no last is ever given; hold keeps in_start high; rst_at >= 0 resets mid-payload.
  task automatic run_frame(input string name, input int n, input int drop_at, input bit over,
                           input bit hold, input int rst_at);
    logic [47:0] d, s;
    logic [15:0] t;
    logic        ready_s, acc;
    int idx, cyc, ur_cyc, done_cyc, sent, mism;
    bit done, full;
    logic [7:0] tail[$];

    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    d = {16'($urandom), $urandom};
    s = {16'($urandom), $urandom};
    t = 16'($urandom);
    in_dest_mac = d;
    in_src_mac = s;
    in_ether_type = t;
    in_start = 1'b1;
    in_data_valid = 1'b0;
    cap.delete();
    @(posedge in_clk); #1;
    check({name, "/start_txen"},     32'(out_txen),     32'd1);
    check({name, "/start_txd"},      32'(out_txd),      32'h55);
    check({name, "/start_busy"},     32'(out_busy),     32'd1);
    check({name, "/start_flags"},    32'({out_underrun, out_oversize}), 32'd0);
    if (!hold) in_start = 1'b0;

    idx = 0; cyc = 0; ur_cyc = -1; done_cyc = 0; done = 0;
    while (!done && cyc < 2000) begin
      ready_s = out_data_ready;
      in_data_valid = (idx < n) && (idx != drop_at);
      in_data = (idx < n) ? pay[idx] : 8'h00;
      in_data_last = (idx == n - 1) && !over;
      if (hold) begin
        in_dest_mac = {16'($urandom), $urandom};
        in_src_mac = {16'($urandom), $urandom};
        in_ether_type = 16'($urandom);
      end
      if (rst_at >= 0 && ready_s && idx == rst_at) begin
        #2 in_rst_n = 1'b0;
        #1 check_reset_outputs(name);
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
        in_start = 1'b0;
        in_data_valid = 1'b0;
        @(posedge in_clk); #1;
        return;
      end
      acc = ready_s && in_data_valid;
      if (ready_s && !in_data_valid) ur_cyc = cyc;
      @(posedge in_clk); #1;
      cyc++;
      if (acc) idx++;
      if (ready_s && !acc) begin
        check({name, "/ur_txen"}, 32'(out_txen), 32'd0);
        check({name, "/ur_flag"}, 32'(out_underrun), 32'd1);
      end
      if (over && acc && idx == 1500)
        check({name, "/os_ready_low"}, 32'(out_data_ready), 32'd0);
      if (!out_busy) begin
        done = 1;
        done_cyc = cyc;
      end
    end
    if (!done) begin
      check({name, "/timeout"}, 32'd0, 32'd1);
      return;
    end

    full = (drop_at < 0);
    sent = over ? 1500 : (full ? n : drop_at);
    check({name, "/accepted"}, 32'(idx), 32'(sent));
    build_expected(d, s, t, sent, full);
    check({name, "/txen_len"}, 32'(cap.size()), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) mism++;
    check({name, "/octet_mism"}, 32'(mism), 32'd0);
    if (full) begin
      tail.delete();
      for (int i = 8; i < cap.size(); i++) tail.push_back(cap[i]);
      check({name, "/residue"}, crc_of(tail), 32'hDEBB20E3);
    end
    check({name, "/underrun"}, 32'(out_underrun), 32'(!full));
    check({name, "/oversize"}, 32'(out_oversize), 32'(over));
    if (ur_cyc >= 0)
      check({name, "/ur_busy_delay"}, 32'(done_cyc - (ur_cyc + 1)), 32'd12);
    $display("[TB] frame %s n=%0d sent=%0d octets=%0d", name, n, sent, cap.size());
  endtask

  initial begin
    in_rst_n = 1'b0;
    repeat (3) @(posedge in_clk);
    #1 check_reset_outputs("reset");
    in_rst_n = 1'b1;
    @(posedge in_clk); #1;

    run_frame("p46", 46, -1, 1'b0, 1'b0, -1);
    run_frame("p10", 10, -1, 1'b0, 1'b0, -1);
    run_frame("p1", 1, -1, 1'b0, 1'b0, -1);
    run_frame("prand", 47 + int'($urandom_range(0, 150)), -1, 1'b0, 1'b0, -1);
    run_frame("underrun", 60, 19, 1'b0, 1'b0, -1);
    run_frame("oversize", 1501, -1, 1'b1, 1'b0, -1);
    run_frame("after_os", 20, -1, 1'b0, 1'b0, -1);

    run_frame("b2b_a", 50, -1, 1'b0, 1'b1, -1);
    run_frame("b2b_b", 46, -1, 1'b0, 1'b0, -1);
    check("b2b/gap", 32'(gap_at_rise), 32'd13);

    run_frame("rst_mid", 80, -1, 1'b0, 1'b0, 29);
    run_frame("post_rst", 30, -1, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
